elm_layer_controller: RTL and testbench

- Parametrised sequencer for one ELM layer: input-by-weight MAC per neuron, bias add, result-register load, repeated for N_HIDDEN neurons, then export of the layer results.
- Successor to the fixed 4-state hidden-layer controller. It owns its own input and neuron counters, so it no longer uses external done/count10 strobes.
- Adds an accumulator pipeline-drain wait, an optional export phase with a valid/ready handshake, and a start/done handshake.
- Sits between the input-buffer loader (in_ready) and the MAC/bias/register datapath; the export side feeds the output layer.

---
 rtl/elm_ctrl_pkg.sv | 41 ++++
 rtl/elm_mod_counter.sv | 46 ++++
 rtl/elm_layer_controller.sv | 167 ++++++++++++++++
 tb/tb_elm_layer_controller.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/elm_ctrl_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : elm_ctrl_pkg
// Description : Shared state encoding and width/cycle helpers for the ELM
//               layer controller.
// Revision    : 1.0 - initial release
// ============================================================================
package elm_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_INIT   = 3'd1,
        S_MAC    = 3'd2,
        S_DRAIN  = 3'd3,
        S_BIAS   = 3'd4,
        S_LOAD   = 3'd5,
        S_EXPORT = 3'd6,
        S_DONE   = 3'd7
    } elm_state_e;

    localparam logic [2:0] c_ST_IDLE   = S_IDLE;
    localparam logic [2:0] c_ST_INIT   = S_INIT;
    localparam logic [2:0] c_ST_MAC    = S_MAC;
    localparam logic [2:0] c_ST_DRAIN  = S_DRAIN;
    localparam logic [2:0] c_ST_BIAS   = S_BIAS;
    localparam logic [2:0] c_ST_LOAD   = S_LOAD;
    localparam logic [2:0] c_ST_EXPORT = S_EXPORT;
    localparam logic [2:0] c_ST_DONE   = S_DONE;

    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // INIT + MAC terms + drain + BIAS + LOAD
    function automatic int neuron_cycles(input int n_inputs, input int pipe_lat);
        return 3 + n_inputs + pipe_lat;
    endfunction

endpackage
`default_nettype wire

// File: rtl/elm_mod_counter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : elm_mod_counter
// Description : Modulo counter 0..MAX with clear, increment and last flag.
// Revision    : 1.0 - initial release
// ============================================================================
module elm_mod_counter #(
    parameter int WIDTH = 1,
    parameter int MAX   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] value,
    output logic             last
);

    localparam logic [WIDTH-1:0] c_MAX = WIDTH'(MAX);

    logic [WIDTH-1:0] r_value_q;
    logic [WIDTH-1:0] w_value_d;

    always_comb begin
        w_value_d = r_value_q;
        if (clr) begin
            w_value_d = '0;
        end else if (inc) begin
            w_value_d = (r_value_q == c_MAX) ? '0 : r_value_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_value_q <= '0;
        end else begin
            r_value_q <= w_value_d;
        end
    end

    assign value = r_value_q;
    assign last  = (r_value_q == c_MAX);

endmodule
`default_nettype wire

// File: rtl/elm_layer_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : elm_layer_controller
// Description : Moore sequencer for one ELM layer: per-neuron MAC, drain,
//               bias, register load, then optional handshaked export.
// Revision    : 1.0 - initial release
// ============================================================================
module elm_layer_controller
    import elm_ctrl_pkg::*;
#(
    parameter int N_INPUTS  = 256,
    parameter int N_HIDDEN  = 10,
    parameter int PIPE_LAT  = 0,
    parameter int EXPORT_EN = 1,
    parameter int IN_AW     = clog2_min1(N_INPUTS),
    parameter int HID_AW    = clog2_min1(N_HIDDEN)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_ready,
    input  logic              out_ready,
    output logic              initialise,
    output logic              en_acc,
    output logic              rst_acc,
    output logic              en_bias,
    output logic              rst_bias,
    output logic              en_reg,
    output logic              rst_reg,
    output logic [IN_AW-1:0]  in_addr,
    output logic [HID_AW-1:0] neuron_idx,
    output logic              export_valid,
    output logic [HID_AW-1:0] export_idx,
    output logic              busy,
    output logic              done
);

    localparam int c_DRAIN_AW  = clog2_min1(PIPE_LAT);
    localparam int c_DRAIN_MAX = (PIPE_LAT > 0) ? PIPE_LAT - 1 : 0;
    localparam logic [c_DRAIN_AW-1:0] c_DRAIN_LAST = c_DRAIN_AW'(c_DRAIN_MAX);

    logic [2:0] r_state_q;
    logic [2:0] w_state_d;
    logic       r_pending_q;
    logic       w_pending_d;

    logic w_in_clr, w_in_inc, w_in_last;
    logic w_drain_inc, w_drain_last;
    logic w_nrn_inc, w_nrn_last;
    logic w_exp_inc, w_exp_last;
    logic [c_DRAIN_AW-1:0] w_drain_cnt;

    elm_mod_counter #(.WIDTH(IN_AW), .MAX(N_INPUTS - 1)) u_in_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (w_in_clr),
        .inc   (w_in_inc),
        .value (in_addr),
        .last  (w_in_last)
    );

    elm_mod_counter #(.WIDTH(c_DRAIN_AW), .MAX(c_DRAIN_MAX)) u_drain_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (1'b0),
        .inc   (w_drain_inc),
        .value (w_drain_cnt),
        .last  (w_drain_last)
    );

    elm_mod_counter #(.WIDTH(HID_AW), .MAX(N_HIDDEN - 1)) u_nrn_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (1'b0),
        .inc   (w_nrn_inc),
        .value (neuron_idx),
        .last  (w_nrn_last)
    );

    elm_mod_counter #(.WIDTH(HID_AW), .MAX(N_HIDDEN - 1)) u_exp_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (1'b0),
        .inc   (w_exp_inc),
        .value (export_idx),
        .last  (w_exp_last)
    );

    assign w_in_clr = (r_state_q == c_ST_INIT);

    always_comb begin
        w_state_d   = r_state_q;
        w_pending_d = r_pending_q;
        w_in_inc    = 1'b0;
        w_drain_inc = 1'b0;
        w_nrn_inc   = 1'b0;
        w_exp_inc   = 1'b0;
        case (r_state_q)
            c_ST_IDLE: begin
                // A start seen while the input buffer is still loading is remembered
                if (in_ready && (start || r_pending_q)) begin
                    w_state_d   = c_ST_INIT;
                    w_pending_d = 1'b0;
                end else if (start) begin
                    w_pending_d = 1'b1;
                end
            end
            c_ST_INIT: w_state_d = c_ST_MAC;
            c_ST_MAC: begin
                w_in_inc = 1'b1;
                if (w_in_last) begin
                    w_state_d = (PIPE_LAT > 0) ? c_ST_DRAIN : c_ST_BIAS;
                end
            end
            c_ST_DRAIN: begin
                w_drain_inc = 1'b1;
                if (w_drain_last && (w_drain_cnt == c_DRAIN_LAST)) begin
                    w_state_d = c_ST_BIAS;
                end
            end
            c_ST_BIAS: w_state_d = c_ST_LOAD;
            c_ST_LOAD: begin
                w_nrn_inc = 1'b1;
                if (w_nrn_last) begin
                    w_state_d = (EXPORT_EN != 0) ? c_ST_EXPORT : c_ST_DONE;
                end else begin
                    w_state_d = c_ST_INIT;
                end
            end
            c_ST_EXPORT: begin
                if (out_ready) begin
                    w_exp_inc = 1'b1;
                    if (w_exp_last) begin
                        w_state_d = c_ST_DONE;
                    end
                end
            end
            c_ST_DONE: w_state_d = c_ST_IDLE;
            default:   w_state_d = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q   <= c_ST_IDLE;
            r_pending_q <= 1'b0;
        end else begin
            r_state_q   <= w_state_d;
            r_pending_q <= w_pending_d;
        end
    end

    assign initialise   = (r_state_q == c_ST_INIT);
    assign en_acc       = (r_state_q == c_ST_MAC);
    assign rst_acc      = (r_state_q == c_ST_IDLE) || (r_state_q == c_ST_INIT) ||
                          (r_state_q == c_ST_EXPORT);
    assign en_bias      = (r_state_q == c_ST_BIAS);
    assign rst_bias     = (r_state_q == c_ST_IDLE) || (r_state_q == c_ST_EXPORT);
    assign en_reg       = (r_state_q == c_ST_LOAD);
    assign rst_reg      = (r_state_q == c_ST_IDLE);
    assign export_valid = (r_state_q == c_ST_EXPORT);
    assign busy         = (r_state_q != c_ST_IDLE);
    assign done         = (r_state_q == c_ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_elm_layer_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_elm_layer_controller
// Description : Two-configuration bench comparing the controller against a
//               phase/offset reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_elm_layer_controller;
    import elm_ctrl_pkg::*;

    localparam int A_NI = 4, A_NH = 3, A_PL = 2, A_EE = 1;
    localparam int B_NI = 1, B_NH = 1, B_PL = 0, B_EE = 0;
    localparam int M_IDLE = 0, M_RUN = 1, M_EXP = 2, M_DONE = 3;

    typedef struct {
        int mode;
        int t;
        int ex;
        bit pending;
    } mdl_t;

    logic clk = 1'b0;
    logic rst, start, in_ready, out_ready;

    logic a_init, a_en_acc, a_rst_acc, a_en_bias, a_rst_bias, a_en_reg, a_rst_reg;
    logic a_ev, a_busy, a_done;
    logic [1:0] a_in_addr, a_nrn, a_exp;
    logic b_init, b_en_acc, b_rst_acc, b_en_bias, b_rst_bias, b_en_reg, b_rst_reg;
    logic b_ev, b_busy, b_done;
    logic [0:0] b_in_addr, b_nrn, b_exp;

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   done_cnt_a = 0, done_cnt_b = 0, last_done_a = 0, b_ev_seen = 0;
    mdl_t ma, mb;

    always #5 clk = ~clk;

    elm_layer_controller #(.N_INPUTS(A_NI), .N_HIDDEN(A_NH), .PIPE_LAT(A_PL), .EXPORT_EN(A_EE)) u_dut_a (
        .clk(clk), .rst(rst), .start(start), .in_ready(in_ready), .out_ready(out_ready),
        .initialise(a_init), .en_acc(a_en_acc), .rst_acc(a_rst_acc), .en_bias(a_en_bias),
        .rst_bias(a_rst_bias), .en_reg(a_en_reg), .rst_reg(a_rst_reg), .in_addr(a_in_addr),
        .neuron_idx(a_nrn), .export_valid(a_ev), .export_idx(a_exp), .busy(a_busy), .done(a_done)
    );

    elm_layer_controller #(.N_INPUTS(B_NI), .N_HIDDEN(B_NH), .PIPE_LAT(B_PL), .EXPORT_EN(B_EE)) u_dut_b (
        .clk(clk), .rst(rst), .start(start), .in_ready(in_ready), .out_ready(out_ready),
        .initialise(b_init), .en_acc(b_en_acc), .rst_acc(b_rst_acc), .en_bias(b_en_bias),
        .rst_bias(b_rst_bias), .en_reg(b_en_reg), .rst_reg(b_rst_reg), .in_addr(b_in_addr),
        .neuron_idx(b_nrn), .export_valid(b_ev), .export_idx(b_exp), .busy(b_busy), .done(b_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, obs, expv);
        end
    endtask

    function automatic mdl_t mdl_step(mdl_t m, int ni, int nh, int pl, int ee,
                                      bit r, bit st, bit ir, bit orr);
        mdl_t n = m;
        int nc = neuron_cycles(ni, pl);
        if (r) begin
            n.mode = M_IDLE; n.t = 0; n.ex = 0; n.pending = 1'b0;
            return n;
        end
        case (m.mode)
            M_IDLE: begin
                if (ir && (st || m.pending)) begin
                    n.mode = M_RUN; n.t = 0; n.pending = 1'b0;
                end else if (st) begin
                    n.pending = 1'b1;
                end
            end
            M_RUN: begin
                n.t = m.t + 1;
                if (n.t == nh * nc) begin
                    n.t = 0;
                    n.mode = (ee != 0) ? M_EXP : M_DONE;
                end
            end
            M_EXP: begin
                if (orr) begin
                    if (m.ex == nh - 1) begin n.ex = 0; n.mode = M_DONE; end
                    else n.ex = m.ex + 1;
                end
            end
            default: n.mode = M_IDLE;
        endcase
        return n;
    endfunction

    // Bits: initialise, en_acc, rst_acc, en_bias, rst_bias, en_reg, rst_reg, export_valid, busy, done
    function automatic logic [9:0] mdl_ctl(mdl_t m, int ni, int pl);
        logic ini = 0, ea = 0, ra = 0, eb = 0, rb = 0, er = 0, rr = 0, ev = 0, dn = 0;
        int off = m.t % neuron_cycles(ni, pl);
        case (m.mode)
            M_IDLE: begin ra = 1; rb = 1; rr = 1; end
            M_RUN: begin
                if (off == 0) begin ini = 1; ra = 1; end
                else if (off <= ni) ea = 1;
                else if (off == ni + pl + 1) eb = 1;
                else if (off == ni + pl + 2) er = 1;
            end
            M_EXP: begin ev = 1; ra = 1; rb = 1; end
            default: dn = 1;
        endcase
        return {ini, ea, ra, eb, rb, er, rr, ev, (m.mode != M_IDLE), dn};
    endfunction

    function automatic int mdl_addr(mdl_t m, int ni, int pl);
        int off = m.t % neuron_cycles(ni, pl);
        return (m.mode == M_RUN && off >= 1 && off <= ni) ? off - 1 : 0;
    endfunction

    function automatic int mdl_nrn(mdl_t m, int ni, int pl);
        return (m.mode == M_RUN) ? m.t / neuron_cycles(ni, pl) : 0;
    endfunction

    task automatic check_all();
        chk("A.ctl", 32'({a_init, a_en_acc, a_rst_acc, a_en_bias, a_rst_bias, a_en_reg, a_rst_reg,
                          a_ev, a_busy, a_done}), 32'(mdl_ctl(ma, A_NI, A_PL)));
        chk("A.in_addr", 32'(a_in_addr), 32'(mdl_addr(ma, A_NI, A_PL)));
        chk("A.neuron_idx", 32'(a_nrn), 32'(mdl_nrn(ma, A_NI, A_PL)));
        chk("A.export_idx", 32'(a_exp), 32'((ma.mode == M_EXP) ? ma.ex : 0));
        chk("B.ctl", 32'({b_init, b_en_acc, b_rst_acc, b_en_bias, b_rst_bias, b_en_reg, b_rst_reg,
                          b_ev, b_busy, b_done}), 32'(mdl_ctl(mb, B_NI, B_PL)));
        chk("B.in_addr", 32'(b_in_addr), 32'(mdl_addr(mb, B_NI, B_PL)));
        chk("B.neuron_idx", 32'(b_nrn), 32'(mdl_nrn(mb, B_NI, B_PL)));
        chk("B.export_idx", 32'(b_exp), 32'((mb.mode == M_EXP) ? mb.ex : 0));
        if (a_done === 1'b1) begin done_cnt_a++; last_done_a = cyc; end
        if (b_done === 1'b1) done_cnt_b++;
        if (b_ev !== 1'b0) b_ev_seen++;
    endtask

    task automatic tick(input bit r, input bit st, input bit ir, input bit orr);
        @(negedge clk);
        cyc++;
        check_all();
        rst = r; start = st; in_ready = ir; out_ready = orr;
        @(posedge clk);
        ma = mdl_step(ma, A_NI, A_NH, A_PL, A_EE, r, st, ir, orr);
        mb = mdl_step(mb, B_NI, B_NH, B_PL, B_EE, r, st, ir, orr);
    endtask

    initial begin
        int s, held, off;
        bit o, st, hit;
        rst = 1'b1; start = 1'b0; in_ready = 1'b0; out_ready = 1'b0;
        ma = '{M_IDLE, 0, 0, 1'b0};
        mb = '{M_IDLE, 0, 0, 1'b0};
        repeat (2) @(posedge clk);
        tick(1, 0, 0, 1);
        tick(0, 0, 1, 1);

        // Full layer, no back-pressure
        done_cnt_a = 0; done_cnt_b = 0;
        s = cyc + 1;
        tick(0, 1, 1, 1);
        repeat (45) tick(0, 0, 1, 1);
        chk("t1_done_count_a", 32'(done_cnt_a), 32'd1);
        chk("t1_latency_a", 32'(last_done_a - s), 32'(A_NH * neuron_cycles(A_NI, A_PL) + A_NH + 1));
        chk("t5_done_count_b", 32'(done_cnt_b), 32'd1);

        // Five cycles of back-pressure at export_idx = 1
        done_cnt_a = 0; held = 0;
        s = cyc + 1;
        tick(0, 1, 1, 1);
        for (int i = 0; i < 60; i++) begin
            o = 1'b1;
            if (ma.mode == M_EXP && ma.ex == 1 && held < 5) begin o = 1'b0; held++; end
            tick(0, 0, 1, o);
        end
        chk("t2_held", 32'(held), 32'd5);
        chk("t2_latency_a", 32'(last_done_a - s), 32'(A_NH * neuron_cycles(A_NI, A_PL) + A_NH + 6));
        chk("t2_done_count_a", 32'(done_cnt_a), 32'd1);

        // Start while input buffer not ready
        tick(0, 1, 0, 1);
        repeat (5) tick(0, 0, 0, 1);
        repeat (40) tick(0, 0, 1, 1);

        // Reset in neuron 1 MAC at in_addr 2
        done_cnt_a = 0; hit = 1'b0;
        tick(0, 1, 1, 1);
        for (int i = 0; i < 40 && !hit; i++) begin
            if (ma.mode == M_RUN && ma.t == neuron_cycles(A_NI, A_PL) + 3) begin
                tick(1, 0, 1, 1);
                hit = 1'b1;
            end else begin
                tick(0, 0, 1, 1);
            end
        end
        chk("t4_reset_hit", 32'(hit), 32'd1);
        repeat (4) tick(0, 0, 1, 1);
        chk("t4_no_done", 32'(done_cnt_a), 32'd0);
        tick(0, 1, 1, 1);
        repeat (40) tick(0, 0, 1, 1);
        chk("t4_rerun_done", 32'(done_cnt_a), 32'd1);

        // start during MAC and DONE is ignored
        done_cnt_a = 0;
        tick(0, 1, 1, 1);
        for (int i = 0; i < 50; i++) begin
            off = ma.t % neuron_cycles(A_NI, A_PL);
            st = (ma.mode == M_RUN && off >= 1 && off <= A_NI) || (ma.mode == M_DONE);
            tick(0, st, 1, 1);
        end
        chk("t6_single_run", 32'(done_cnt_a), 32'd1);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            tick(($urandom_range(0, 199) == 0), ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0));
        end
        tick(0, 0, 1, 1);
        chk("b_export_never", 32'(b_ev_seen), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
